orion_csrf: RTL and testbench
=============================

# orion_csrf

Control and status register file for the Orion RV32 core, sitting at the responder end of the MEM→CSR request path and the CSR→WB response path. It accepts one `mem_csrf_t` request per cycle from the MEM stage and applies RW/RS/RC read-modify-write semantics. It returns the old CSR value to WB one cycle later in a `csrf_wb_t`. It owns the 64-bit cycle and instret counters; instret advances on `wb_csrf_t.instr_retired`.

## Interface
- `XLEN`, 32 (package), register width.
- `CNT_W`, 64, counter width; split into lo/hi halves of `XLEN`.
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_i`  in  `mem_csrf_t`  request: `addr`, `operand`, `op`, `ren`, `wen`. A request is present when `ren|wen`.
- `retire_i`  in  `wb_csrf_t`  `instr_retired` is a one-cycle pulse per retired instruction.
- `rsp_o`  out  `csrf_wb_t`  `rd_v`, the registered old value of the addressed CSR.
- `illegal_o`  out  1  registered; pulses when the request addressed an unimplemented CSR or wrote a read-only CSR.

## Operation
- Implemented CSRs:
  - MCYCLE/MCYCLEH (B00/B80) and MINSTRET/MINSTRETH (B02/B82) are read/write.
  - CYCLE/CYCLEH (C00/C80) and INSTRET/INSTRETH (C02/C82) are read-only aliases of the same counters.
- Read value is the addressed half as held in the cycle the request is presented, before that cycle's increment or write.
- Write data by `op`, where `old` is the current half:
  - `CSR_OP_RW`: `operand`.
  - `CSR_OP_RS`: `old | operand`.
  - `CSR_OP_RC`: `old & ~operand`.
  - Any other `op` encoding with `wen` = 1 is treated as RW.
- The block writes only when `wen` = 1. The decoder already clears `wen` for RS/RC when the operand is zero.
- `ren` = 0 with `wen` = 1: the write is performed and `rd_v` is driven 0.
- Illegal cases:
  - Unimplemented address with `ren|wen`: `rd_v` = 0, `illegal_o` = 1, no state change.
  - `wen` to C00/C02/C80/C82: no state change, `illegal_o` = 1, and `rd_v` still returns the old value if `ren`.
- mcycle increments by 1 every cycle out of reset.
- minstret increments by 1 in each cycle where `retire_i.instr_retired` = 1.
- Both counters are 64-bit. The carry from lo propagates into hi in the same cycle. All-ones wraps to 0.
- Write vs increment in the same cycle: the write wins.
  - The written half takes the new value.
  - The other half of that counter holds.
  - That counter does not increment that cycle; the other counter increments normally.
- Retire pulse and a write to a different counter in the same cycle: both happen.

## Timing
- Reset (async assert, sync deassert expected upstream):
  - mcycle = 0, minstret = 0, `rsp_o.rd_v` = 0, `illegal_o` = 0.
- First clock edge after release: mcycle = 1.
- Request presented in cycle N:
  - `rsp_o.rd_v` and `illegal_o` are valid in cycle N+1 (1-cycle latency).
  - The new CSR value is visible to a read presented in cycle N+1.
- Back-to-back requests are supported, one per cycle, with no stall and no backpressure.
- `rsp_o.rd_v` and `illegal_o` return to 0 the cycle after a cycle with no request.
- Reset asserted mid-request: the request is discarded, outputs are 0 immediately, and no partial write survives.

## Structure
- Package `orion_types` (existing):
  - Uses `csr_addr_t`, `csr_ops_t`, `mem_csrf_t`, `csrf_wb_t`, `wb_csrf_t` as-is.
  - Add `CSR_CNT_W` = 64 there.
- Sub-module `orion_csr_counter`, instantiated twice (cycle, instret):
  - Inputs: `inc_i`, `wr_lo_i`, `wr_hi_i`, `wdata_i`.
  - Outputs: `lo_o`, `hi_o`.
  - Implements the write-wins/hold rule and carry.
- Top level holds the address decode, op ALU, read mux and output registers.

## Test plan
- Reset, release, idle 5 cycles, read MCYCLE (B00) → `rd_v` equals cycles since release (5 when read issued in cycle 5); `illegal_o` = 0.
- CSRRW MCYCLE = 0xFFFF_FFFF, MCYCLEH = 0, then read MCYCLEH two cycles later → 1; lo wrapped to a small count (carry checked).
- Retire pulses on 3 cycles, read INSTRET (C02) → 3. Simultaneous RS on MINSTRET operand 0x10 with a retire pulse → write wins, value = old | 0x10, no increment.
- CSRRC on MCYCLE with operand 0xF → `rd_v` returns the old value; the next read shows low 4 bits cleared (plus elapsed cycles from the cleared base).
- `wen` to CYCLE (C00) → `illegal_o` = 1, counter unchanged. Read of address 0x7B0 → `rd_v` = 0, `illegal_o` = 1.
- Assert `rst_ni` during a MINSTRETH write → minstret = 0, `rd_v` = 0, `illegal_o` = 0 immediately.

Source files
------------

// File: rtl/orion_csrf_pkg.sv
// Shared Orion CSR types: request/response structs, op encodings, CSR addresses,
// plus the address decode and read-modify-write helpers used by orion_csrf.
package orion_types;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CSR_CNT_W = 64;

  typedef logic [11:0] csr_addr_t;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_ops_t;

  typedef struct packed {
    csr_addr_t         addr;
    logic [XLEN-1:0]   operand;
    csr_ops_t          op;
    logic              ren;
    logic              wen;
  } mem_csrf_t;

  typedef struct packed {
    logic [XLEN-1:0] rd_v;
  } csrf_wb_t;

  typedef struct packed {
    logic instr_retired;
  } wb_csrf_t;

  localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
  localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
  localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
  localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
  localparam csr_addr_t CSR_CYCLE     = 12'hC00;
  localparam csr_addr_t CSR_INSTRET   = 12'hC02;
  localparam csr_addr_t CSR_CYCLEH    = 12'hC80;
  localparam csr_addr_t CSR_INSTRETH  = 12'hC82;

  typedef struct packed {
    logic hit;
    logic ro;
    logic is_instret;
    logic is_hi;
  } csr_dec_t;

  function automatic csr_dec_t csr_decode(input csr_addr_t addr);
    csr_dec_t d;
    d = '0;
    case (addr)
      CSR_MCYCLE:    begin d.hit = 1'b1;                                                  end
      CSR_MINSTRET:  begin d.hit = 1'b1; d.is_instret = 1'b1;                             end
      CSR_MCYCLEH:   begin d.hit = 1'b1;                         d.is_hi = 1'b1;          end
      CSR_MINSTRETH: begin d.hit = 1'b1; d.is_instret = 1'b1;    d.is_hi = 1'b1;          end
      CSR_CYCLE:     begin d.hit = 1'b1; d.ro = 1'b1;                                     end
      CSR_INSTRET:   begin d.hit = 1'b1; d.ro = 1'b1; d.is_instret = 1'b1;                end
      CSR_CYCLEH:    begin d.hit = 1'b1; d.ro = 1'b1;                 d.is_hi = 1'b1;     end
      CSR_INSTRETH:  begin d.hit = 1'b1; d.ro = 1'b1; d.is_instret = 1'b1; d.is_hi = 1'b1; end
      default:       d = '0;
    endcase
    return d;
  endfunction

  // Unknown op encodings fall back to a plain write.
  function automatic logic [XLEN-1:0] csr_alu(input csr_ops_t op,
                                              input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] operand);
    case (op)
      CSR_OP_RS: return old | operand;
      CSR_OP_RC: return old & ~operand;
      default:   return operand;
    endcase
  endfunction

endpackage

// File: rtl/orion_csr_counter.sv
// 64-bit counter split into lo/hi halves; a half write wins over the increment
// and freezes the whole counter for that cycle.
module orion_csr_counter
  import orion_types::*;
#(
  parameter int unsigned CNT_W = CSR_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 inc_i,
  input  logic                 wr_lo_i,
  input  logic                 wr_hi_i,
  input  logic [CNT_W/2-1:0]   wdata_i,
  output logic [CNT_W/2-1:0]   lo_o,
  output logic [CNT_W/2-1:0]   hi_o
);

  logic [CNT_W/2-1:0] r_lo;
  logic [CNT_W/2-1:0] r_hi;
  logic [CNT_W-1:0]   w_next;

  assign w_next = {r_hi, r_lo} + CNT_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lo <= '0;
      r_hi <= '0;
    end else if (wr_lo_i) begin
      r_lo <= wdata_i;
    end else if (wr_hi_i) begin
      r_hi <= wdata_i;
    end else if (inc_i) begin
      {r_hi, r_lo} <= w_next;
    end
  end

  assign lo_o = r_lo;
  assign hi_o = r_hi;

endmodule

// File: rtl/orion_csrf.sv
// Orion CSR file: cycle/instret counters with RW/RS/RC access from MEM and a
// registered old-value response to WB one cycle later.
module orion_csrf
  import orion_types::*;
#(
  parameter int unsigned CNT_W = CSR_CNT_W
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  mem_csrf_t req_i,
  input  wb_csrf_t  retire_i,
  output csrf_wb_t  rsp_o,
  output logic      illegal_o
);

  csr_dec_t        w_dec;
  logic            w_req;
  logic            w_wr;
  logic            w_illegal;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_rdata;
  logic [XLEN-1:0] w_cyc_lo, w_cyc_hi, w_ins_lo, w_ins_hi;

  csrf_wb_t        r_rsp;
  logic            r_illegal;

  assign w_dec     = csr_decode(req_i.addr);
  assign w_req     = req_i.ren | req_i.wen;
  assign w_wr      = req_i.wen & w_dec.hit & ~w_dec.ro;
  assign w_illegal = w_req & (~w_dec.hit | (req_i.wen & w_dec.ro));

  always_comb begin
    w_old = '0;
    case ({w_dec.is_instret, w_dec.is_hi})
      2'b00:   w_old = w_cyc_lo;
      2'b01:   w_old = w_cyc_hi;
      2'b10:   w_old = w_ins_lo;
      default: w_old = w_ins_hi;
    endcase
  end

  assign w_wdata = csr_alu(req_i.op, w_old, req_i.operand);
  assign w_rdata = (req_i.ren && w_dec.hit) ? w_old : '0;

  orion_csr_counter #(.CNT_W(CNT_W)) u_cycle (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (1'b1),
    .wr_lo_i (w_wr & ~w_dec.is_instret & ~w_dec.is_hi),
    .wr_hi_i (w_wr & ~w_dec.is_instret &  w_dec.is_hi),
    .wdata_i (w_wdata),
    .lo_o    (w_cyc_lo),
    .hi_o    (w_cyc_hi)
  );

  orion_csr_counter #(.CNT_W(CNT_W)) u_instret (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (retire_i.instr_retired),
    .wr_lo_i (w_wr & w_dec.is_instret & ~w_dec.is_hi),
    .wr_hi_i (w_wr & w_dec.is_instret &  w_dec.is_hi),
    .wdata_i (w_wdata),
    .lo_o    (w_ins_lo),
    .hi_o    (w_ins_hi)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_rsp.rd_v <= w_rdata;
      r_illegal  <= w_illegal;
    end
  end

  assign rsp_o     = r_rsp;
  assign illegal_o = r_illegal;

endmodule

// File: tb/tb_orion_csrf.sv
// Directed bench for orion_csrf: counters, RW/RS/RC, read-only/unimplemented
// accesses and mid-request reset.
module tb_orion_csrf;
  import orion_types::*;

  logic      clk;
  logic      rst_n;
  mem_csrf_t req;
  wb_csrf_t  retire;
  csrf_wb_t  rsp;
  logic      illegal;

  int n_tests = 0;
  int n_fail  = 0;

  orion_csrf #(.CNT_W(64)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .retire_i  (retire),
    .rsp_o     (rsp),
    .illegal_o (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input csr_addr_t a, input logic [31:0] opd, input csr_ops_t op,
                       input logic ren, input logic wen);
    req.addr    = a;
    req.operand = opd;
    req.op      = op;
    req.ren     = ren;
    req.wen     = wen;
  endtask

  task automatic rd(input csr_addr_t a);
    drive(a, 32'h0, CSR_OP_NONE, 1'b1, 1'b0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    retire = '0;
    tick; tick;
    check("reset_rd_v", rsp.rd_v, 32'h0);
    check("reset_illegal", {31'b0, illegal}, 32'h0);

    // Release just after an edge; 5 edges later mcycle = 5.
    rst_n = 1'b1;
    tick; tick; tick; tick; tick;
    rd(CSR_MCYCLE); tick;
    check("mcycle_after_5", rsp.rd_v, 32'd5);
    check("mcycle_legal", {31'b0, illegal}, 32'h0);

    // mcycle = 6 here; force lo to all-ones and hi to 0.
    drive(CSR_MCYCLE, 32'hFFFF_FFFF, CSR_OP_RW, 1'b1, 1'b1); tick;
    check("rw_mcycle_old", rsp.rd_v, 32'd6);
    drive(CSR_MCYCLEH, 32'h0, CSR_OP_RW, 1'b1, 1'b1); tick;
    check("rw_mcycleh_old", rsp.rd_v, 32'h0);
    req = '0; tick;
    check("idle_rd_v_zero", rsp.rd_v, 32'h0);
    rd(CSR_MCYCLEH); tick;
    check("carry_into_hi", rsp.rd_v, 32'd1);
    rd(CSR_MCYCLE); tick;
    check("lo_wrapped", rsp.rd_v, 32'd1);

    // Three retire pulses.
    req = '0;
    retire.instr_retired = 1'b1;
    tick; tick; tick;
    retire.instr_retired = 1'b0;
    rd(CSR_INSTRET); tick;
    check("instret_3", rsp.rd_v, 32'd3);
    check("instret_ro_read_legal", {31'b0, illegal}, 32'h0);
    drive(CSR_MINSTRET, 32'h10, CSR_OP_RS, 1'b1, 1'b1);
    retire.instr_retired = 1'b1;
    tick;
    retire.instr_retired = 1'b0;
    check("rs_minstret_old", rsp.rd_v, 32'd3);
    rd(CSR_MINSTRET); tick;
    check("rs_write_wins", rsp.rd_v, 32'h13);
    rd(CSR_INSTRETH); tick;
    check("instreth_zero", rsp.rd_v, 32'h0);

    // mcycle lo = 9, hi = 1.
    drive(CSR_MCYCLE, 32'hA5, CSR_OP_RW, 1'b1, 1'b1); tick;
    check("rw_mcycle_old2", rsp.rd_v, 32'd9);
    drive(CSR_MCYCLE, 32'hF, CSR_OP_RC, 1'b1, 1'b1); tick;
    check("rc_old", rsp.rd_v, 32'hA5);
    rd(CSR_MCYCLE); tick;
    check("rc_cleared", rsp.rd_v, 32'hA0);
    req = '0; tick;
    rd(CSR_MCYCLE); tick;
    check("rc_then_count", rsp.rd_v, 32'hA2);
    rd(CSR_CYCLEH); tick;
    check("hi_held_on_lo_write", rsp.rd_v, 32'd1);

    // mcycle lo = A4: write to read-only alias.
    drive(CSR_CYCLE, 32'h0, CSR_OP_RW, 1'b1, 1'b1); tick;
    check("ro_write_rd_v", rsp.rd_v, 32'hA4);
    check("ro_write_illegal", {31'b0, illegal}, 32'h1);
    rd(CSR_MCYCLE); tick;
    check("ro_write_no_change", rsp.rd_v, 32'hA5);
    check("legal_after_illegal", {31'b0, illegal}, 32'h0);
    rd(12'h7B0); tick;
    check("unimpl_rd_v", rsp.rd_v, 32'h0);
    check("unimpl_illegal", {31'b0, illegal}, 32'h1);

    // Write-only access with an unassigned op encoding acts as RW.
    drive(CSR_MINSTRET, 32'h55, CSR_OP_NONE, 1'b0, 1'b1); tick;
    check("wonly_rd_v_zero", rsp.rd_v, 32'h0);
    check("wonly_legal", {31'b0, illegal}, 32'h0);
    rd(CSR_MINSTRET); tick;
    check("other_op_is_rw", rsp.rd_v, 32'h55);

    // Reset mid-request during a MINSTRETH write.
    drive(CSR_MINSTRETH, 32'h7, CSR_OP_RW, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rd_v", rsp.rd_v, 32'h0);
    check("midrst_illegal", {31'b0, illegal}, 32'h0);
    tick;
    rst_n = 1'b1;
    rd(CSR_MINSTRETH); tick;
    check("midrst_no_partial_write", rsp.rd_v, 32'h0);
    rd(CSR_MINSTRET); tick;
    check("midrst_minstret_zero", rsp.rd_v, 32'h0);
    rd(CSR_MCYCLE); tick;
    check("midrst_mcycle_restart", rsp.rd_v, 32'd2);
    req = '0; tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
